// File: rtl/morse_pkg.sv
// Purpose: shared constants and the FSM state type for the Morse key sequencer.
//   KEY_*   : keypad scan codes with a Morse meaning
//   state_e : sequencer states (IDLE, BUILD, OUT)
package morse_pkg;

  localparam logic [3:0] KEY_DOT    = 4'h0;
  localparam logic [3:0] KEY_DASH   = 4'h1;
  localparam logic [3:0] KEY_BKSP   = 4'hE;
  localparam logic [3:0] KEY_COMMIT = 4'hF;
  localparam logic [3:0] KEY_WSPACE = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/key_release_sync.sv
// Purpose: brings the keypad scanner's key_flag into the clk domain and
//   reports key releases.
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   key_flag_i   raw key-pressed flag (asynchronous to clk_i)
//   key_val_i    key code, stable whenever key_flag_i is low
//   rel_pulse_o  one-cycle pulse on a 1->0 transition of the synced flag
//   key_val_o    key code to sample together with rel_pulse_o
module key_release_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_flag_i,
  input  logic [3:0] key_val_i,
  output logic       rel_pulse_o,
  output logic [3:0] key_val_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= key_flag_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rel_pulse_o = hist_q & ~sync2_q;
  // The scanner holds the code stable while the flag is low, and a release
  // is only seen after the flag has gone low, so no capture register is needed.
  assign key_val_o   = key_val_i;

endmodule

// File: rtl/morse_key_sequencer.sv
// Purpose: turns keypad key releases into Morse symbol records.
//   0 = dot, 1 = dash, E = backspace, F = commit, A = word space.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   key_flag, key_val     keypad scanner flag (async) and key code
//   sym_valid, sym_ready  record handshake to the decoder
//   sym_len, sym_bits     record: element count (0 = word space), elements
//   building              a symbol is being keyed
//   err_pulse             one-cycle pulse: element overflow or key dropped in OUT
//
// Handshake: sym_valid is high exactly while in OUT; sym_len/sym_bits hold
// until a cycle with sym_valid & sym_ready, after which the sequencer is IDLE
// with the record cleared. sym_valid is a decode of the state register only,
// so sym_ready never reaches it combinationally.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_LEN    = 5,
  parameter int GAP_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_flag,
  input  logic [3:0]         key_val,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic [2:0]         sym_len,
  output logic [MAX_LEN-1:0] sym_bits,
  output logic               building,
  output logic               err_pulse
);

  localparam int             GW       = $clog2(GAP_CYCLES);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_ONE  = GW'(1);
  localparam logic [2:0]     LEN_MAX  = 3'(MAX_LEN);

  logic       rel;
  logic [3:0] key;

  key_release_sync u_sync (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_flag_i  (key_flag),
    .key_val_i   (key_val),
    .rel_pulse_o (rel),
    .key_val_o   (key)
  );

  state_e             state_q, state_d;
  logic [2:0]         len_q, len_d;
  logic [MAX_LEN-1:0] bits_q, bits_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               err_q, err_d;

  logic is_elem;
  logic is_dash;

  assign is_elem = rel && (key == KEY_DOT || key == KEY_DASH);
  assign is_dash = (key == KEY_DASH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= 3'd0;
      bits_q  <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bits_d  = bits_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        if (is_elem) begin
          bits_d    = '0;
          bits_d[0] = is_dash;
          len_d     = 3'd1;
          state_d   = ST_BUILD;
        end else if (rel && key == KEY_WSPACE) begin
          bits_d  = '0;
          len_d   = 3'd0;
          state_d = ST_OUT;
        end
      end
      ST_BUILD: begin
        if (is_elem) begin
          gap_d = '0;
          if (len_q == LEN_MAX) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (i == int'(len_q)) bits_d[i] = is_dash;
            end
            len_d = len_q + 3'd1;
          end
        end else if (rel && key == KEY_BKSP) begin
          gap_d = '0;
          for (int i = 0; i < MAX_LEN; i++) begin
            if (i + 1 == int'(len_q)) bits_d[i] = 1'b0;
          end
          len_d = len_q - 3'd1;
          if (len_q == 3'd1) state_d = ST_IDLE;
        end else if (rel && (key == KEY_COMMIT || key == KEY_WSPACE)) begin
          // A word space closes the open symbol only; the user keys A again
          // to emit the space itself.
          gap_d   = '0;
          state_d = ST_OUT;
        end else begin
          // Ignored keys do not count as activity for the auto-commit gap.
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = ST_OUT;
          end else if (gap_q != '1) begin
            gap_d = gap_q + GAP_ONE;
          end
        end
      end
      ST_OUT: begin
        gap_d = '0;
        if (rel) err_d = 1'b1;
        if (sym_ready) begin
          len_d   = 3'd0;
          bits_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        len_d   = 3'd0;
        bits_d  = '0;
        gap_d   = '0;
      end
    endcase
  end

  assign sym_valid = (state_q == ST_OUT);
  assign building  = (state_q == ST_BUILD);
  assign sym_len   = len_q;
  assign sym_bits  = bits_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
module tb_morse_key_sequencer;

  localparam int MAX_LEN = 5;
  localparam int GAP     = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_flag = 1'b0;
  logic [3:0] key_val = 4'h0;
  logic sym_ready = 1'b0;
  logic sym_valid;
  logic [2:0] sym_len;
  logic [MAX_LEN-1:0] sym_bits;
  logic building;
  logic err_pulse;

  always #5 clk = ~clk;

  morse_key_sequencer #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_flag  (key_flag),
    .key_val   (key_val),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_len   (sym_len),
    .sym_bits  (sym_bits),
    .building  (building),
    .err_pulse (err_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The symbol is a queue of elements; "holding" means a record is offered.
  bit         elems[$];
  bit         holding = 1'b0;
  bit         m_err = 1'b0;
  int         idle_cnt = 0;
  int         cyc = 0;
  int         last_ev_cyc = 0;
  bit         r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;  // raw flag samples, r1 newest
  bit         rst_seen = 1'b0;
  logic [7:0] exp_q[$];

  function automatic logic [MAX_LEN-1:0] model_bits();
    logic [MAX_LEN-1:0] b;
    b = '0;
    for (int i = 0; i < elems.size(); i++) b[i] = elems[i];
    return b;
  endfunction

  always @(posedge clk) begin
    bit ev;
    bit was_holding;
    logic [3:0] kv;
    cyc++;
    m_err = 1'b0;
    if (!rst_n) begin
      elems.delete();
      holding  = 1'b0;
      idle_cnt = 0;
      r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
      exp_q.delete();
      rst_seen = 1'b1;
    end else begin
      ev = r3 && !r2;
      kv = key_val;
      was_holding = holding;
      if (holding) begin
        if (ev) m_err = 1'b1;
        if (sym_ready) begin
          holding = 1'b0;
          elems.delete();
        end
      end else if (elems.size() == 0) begin
        if (ev && (kv == 4'h0 || kv == 4'h1)) begin
          elems.push_back(kv[0]);
          idle_cnt = 0;
          last_ev_cyc = cyc;
        end else if (ev && kv == 4'hA) begin
          holding = 1'b1;
        end
      end else begin
        if (ev && (kv == 4'h0 || kv == 4'h1)) begin
          if (elems.size() < MAX_LEN) elems.push_back(kv[0]);
          else m_err = 1'b1;
          idle_cnt = 0;
          last_ev_cyc = cyc;
        end else if (ev && kv == 4'hE) begin
          void'(elems.pop_back());
          idle_cnt = 0;
          last_ev_cyc = cyc;
        end else if (ev && (kv == 4'hF || kv == 4'hA)) begin
          holding = 1'b1;
        end else begin
          idle_cnt++;
          if (idle_cnt == GAP) holding = 1'b1;
        end
      end
      if (holding && !was_holding) exp_q.push_back({3'(elems.size()), model_bits()});
      r3 = r2; r2 = r1; r1 = key_flag;
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic [7:0] got_q[$];
  int  err_cnt = 0;
  int  valid_cnt = 0;
  int  rise_cyc = 0;
  bit  prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_seen) begin
      check("valid", int'(sym_valid), int'(holding));
      check("building", int'(building), int'(!holding && elems.size() > 0));
      check("len", int'(sym_len), elems.size());
      check("bits", int'(sym_bits), int'(model_bits()));
      check("err", int'(err_pulse), int'(m_err));
      if (rst_n && sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_record", 1, 0);
        end else begin
          check("sb_record", int'({sym_len, sym_bits}), int'(exp_q.pop_front()));
        end
        got_q.push_back({sym_len, sym_bits});
      end
      if (err_pulse) err_cnt++;
      if (sym_valid) valid_cnt++;
      if (sym_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = sym_valid;
    end
  end

  // ---------------- drivers ----------------
  int rdy_mode = 1;  // 0: ready low, 1: ready high, 2: random
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: sym_ready = 1'b0;
        1: sym_ready = 1'b1;
        default: sym_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic press_key(input logic [3:0] k);
    @(posedge clk);
    #($urandom_range(1, 8));
    key_flag = 1'b1;
    #1;
    key_val = k;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #($urandom_range(1, 9));
    key_flag = 1'b0;
    repeat ($urandom_range(5, 8)) @(posedge clk);
  endtask

  function automatic logic [3:0] rand_key();
    int r;
    int v;
    r = $urandom_range(0, 9);
    if (r < 3) return 4'h0;
    if (r < 6) return 4'h1;
    if (r == 6) return 4'hE;
    if (r == 7) return 4'hF;
    if (r == 8) return 4'hA;
    v = $urandom_range(2, 12);
    if (v >= 10) v++;
    return 4'(v);
  endfunction

  // ---------------- directed tests + random phase ----------------
  int e0;
  int v0;

  initial begin
    // Test 1: 0, 1, F with ready held high
    rdy_mode = 1;
    apply_reset();
    got_q.delete();
    v0 = valid_cnt;
    press_key(4'h0); press_key(4'h1); press_key(4'hF);
    wait_cycles(6);
    check("t1_records", got_q.size(), 1);
    if (got_q.size() > 0) check("t1_record", int'(got_q[0]), int'({3'd2, 5'b00010}));
    check("t1_valid_cycles", valid_cnt - v0, 1);

    // Test 2: overflow on sixth element
    apply_reset();
    got_q.delete();
    e0 = err_cnt;
    repeat (5) press_key(4'h1);
    press_key(4'h0);
    press_key(4'hF);
    wait_cycles(6);
    check("t2_err_count", err_cnt - e0, 1);
    check("t2_records", got_q.size(), 1);
    if (got_q.size() > 0) check("t2_record", int'(got_q[0]), int'({3'd5, 5'b11111}));

    // Test 3: auto-commit after the idle gap
    apply_reset();
    got_q.delete();
    press_key(4'h0); press_key(4'h1); press_key(4'hE); press_key(4'h1);
    wait_cycles(GAP + 10);
    check("t3_records", got_q.size(), 1);
    if (got_q.size() > 0) check("t3_record", int'(got_q[0]), int'({3'd2, 5'b00010}));
    check("t3_gap_latency", rise_cyc - last_ev_cyc, 100);

    // Test 4: word space held with ready low, dropped key, then accept
    rdy_mode = 0;
    apply_reset();
    got_q.delete();
    press_key(4'hA);
    wait_cycles(20);
    @(negedge clk);
    check("t4_valid_held", int'(sym_valid), 1);
    check("t4_len", int'(sym_len), 0);
    check("t4_bits", int'(sym_bits), 0);
    e0 = err_cnt;
    press_key(4'h0);
    check("t4_err_in_out", err_cnt - e0, 1);
    rdy_mode = 1;
    wait_cycles(3);
    @(negedge clk);
    check("t4_records", got_q.size(), 1);
    if (got_q.size() > 0) check("t4_record", int'(got_q[0]), 0);
    check("t4_idle_valid", int'(sym_valid), 0);
    check("t4_idle_building", int'(building), 0);

    // Test 5: reset mid-record
    apply_reset();
    got_q.delete();
    press_key(4'h1); press_key(4'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", int'(sym_valid), 0);
    check("t5_rst_len", int'(sym_len), 0);
    check("t5_rst_bits", int'(sym_bits), 0);
    check("t5_rst_building", int'(building), 0);
    check("t5_rst_err", int'(err_pulse), 0);
    press_key(4'hF);
    wait_cycles(GAP + 10);
    check("t5_records", got_q.size(), 0);

    // Test 6: backspace to empty returns to IDLE
    apply_reset();
    got_q.delete();
    press_key(4'h0); press_key(4'hE);
    @(negedge clk);
    check("t6_building", int'(building), 0);
    press_key(4'hF);
    wait_cycles(GAP + 10);
    check("t6_records", got_q.size(), 0);

    // Random phase
    rdy_mode = 2;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      press_key(rand_key());
      if ($urandom_range(0, 19) == 0) wait_cycles($urandom_range(GAP - 5, GAP + 20));
      if ($urandom_range(0, 49) == 0) apply_reset();
    end
    rdy_mode = 1;
    wait_cycles(GAP + 20);
    check("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
